// File: rtl/key_pkg.sv
// key_pkg: shared types and constants for the key conditioning block.
//   key_state_t        - per-channel debounce FSM state
//   KEY_DEBOUNCE_50MHZ - default qualification length (10 ms at 50 MHz)
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_QUAL,
    PRESSED,
    RELEASE_QUAL
  } key_state_t;

  localparam int KEY_DEBOUNCE_50MHZ = 500000;

endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one key's synchronizer, debounce FSM and counter.
// Ports:
//   CLOCK_50      in   system clock
//   reset         in   async, active-high
//   key_n         in   raw active-low button, asynchronous
//   press_pulse   out  registered one-cycle pulse per accepted press
//   release_pulse out  registered one-cycle pulse per accepted release
//   key_held      out  registered debounced pressed level
//   press_fire    out  combinational: press_pulse will be set on the next edge
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_50MHZ,
  parameter int SYNC_STAGES     = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic key_held,
  output logic press_fire
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  key_state_t             state;
  logic [CW-1:0]          cnt;
  logic                   s;

  // Synchronized pressed level (buttons are active-low).
  assign s = ~sync[SYNC_STAGES-1];

  // Lets the top register any_press in the same cycle as press_pulse.
  assign press_fire = (state == PRESS_QUAL) && s && (cnt == LAST);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync          <= '1;
      state         <= RELEASED;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      key_held      <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], key_n};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (s) begin
            state <= PRESS_QUAL;
            cnt   <= '0;
          end
        end
        PRESS_QUAL: begin
          if (!s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            key_held    <= 1'b1;
            cnt         <= '0;   // counter parks at 0 while held
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= RELEASE_QUAL;
            cnt   <= '0;
          end
        end
        RELEASE_QUAL: begin
          // key_held stays 1 here; a dropout shorter than qualification is invisible
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state         <= RELEASED;
            release_pulse <= 1'b1;
            key_held      <= 1'b0;
            cnt           <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_pulse_conditioner.sv
// key_pulse_conditioner: debounces NUM_KEYS active-low push-buttons into
// press/release pulses and held levels for the game controller.
// Ports:
//   CLOCK_50      in   system clock
//   reset         in   async, active-high
//   key_n         in   [NUM_KEYS] raw buttons, active-low, asynchronous
//   press_pulse   out  [NUM_KEYS] one-cycle pulse per accepted press
//   release_pulse out  [NUM_KEYS] one-cycle pulse per accepted release
//   key_held      out  [NUM_KEYS] debounced pressed level
//   any_press     out  registered OR of press_pulse
module key_pulse_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_50MHZ,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                any_press
);

  logic [NUM_KEYS-1:0] press_fire;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_ch (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .key_n        (key_n[gi]),
      .press_pulse  (press_pulse[gi]),
      .release_pulse(release_pulse[gi]),
      .key_held     (key_held[gi]),
      .press_fire   (press_fire[gi])
    );
  end

  // Registered from the channels' next-cycle press terms so it lines up
  // exactly with press_pulse.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) any_press <= 1'b0;
    else       any_press <= |press_fire;
  end

endmodule
